key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Front-end conditioning for the DE2 push-buttons and the slide-switch mode keys before they reach the recorder/player control FSM. Per key it does four things: synchronises the raw pin into the i_clk domain, debounces it, and produces a clean level, one-cycle press and release pulses, a one-shot long-press pulse, and a toggle bit. The control FSM consumes the press pulses as start/pause/stop/back commands, and the toggle and long-press bits as mode selects.

Parameters:
N_KEYS, 5, number of independent key channels
DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a level change (>=2)
LONG_PRESS_CYCLES, 50000000, cycles of accepted-pressed level before o_long fires (> DEBOUNCE_CYCLES)
ACTIVE_LOW, 1, 1 means a raw pin reading 0 is "pressed"

Ports:
i_clk  input  1  system clock; all logic is on its rising edge
i_rst_n  input  1  reset; asynchronous, active-low
i_key  input  N_KEYS  raw asynchronous key pins
o_level  output  N_KEYS  debounced pressed level (1 = pressed)
o_press  output  N_KEYS  one-cycle pulse on accepted press
o_release  output  N_KEYS  one-cycle pulse on accepted release
o_long  output  N_KEYS  one-cycle pulse, once per press, after LONG_PRESS_CYCLES held
o_toggle  output  N_KEYS  flips on every o_press

Behaviour:
- Interface fixed: one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0, all counters 0.
  - Synchroniser flops reset to the released pin value (1 if ACTIVE_LOW, else 0), so no spurious event occurs out of reset.
- Channels are fully independent. All outputs are registered, and there is no combinational path from i_key to any output.
- Sync stage: 2-flop synchroniser per key. The normalised sample s = sync2 XOR ACTIVE_LOW (1 = pressed).
- Debounce: per-key counter, width $clog2(DEBOUNCE_CYCLES).
  - While s == o_level: the counter holds 0.
  - While s != o_level: the counter increments each cycle.
  - On the cycle where s != o_level and the counter == DEBOUNCE_CYCLES-1: o_level <= s, the counter clears, and the matching pulse is registered on the same edge.
  - Any cycle with s == o_level clears the counter. A glitch shorter than DEBOUNCE_CYCLES therefore produces no event.
- Latency: a clean pin transition moves o_level exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples the new pin value.
- Pulse timing:
  - o_press is high for exactly the one cycle in which o_level first reads 1.
  - o_release is high for exactly the one cycle in which o_level first reads 0.
  - The two pulses never assert together on one key.
- Per-key FSM:
  - States: RELEASED, PRESSED, LONG_DONE.
  - RELEASED -> PRESSED on an accepted press; the hold counter clears.
  - PRESSED: the hold counter increments each cycle. When it reaches LONG_PRESS_CYCLES-1, o_long pulses for one cycle and the FSM goes to LONG_DONE.
  - PRESSED or LONG_DONE -> RELEASED on an accepted release.
  - The hold counter saturates. o_long fires at most once per press, and never if released first.
  - Hold counter width: $clog2(LONG_PRESS_CYCLES).
- o_long timing: the pulse occurs LONG_PRESS_CYCLES cycles after the o_press cycle. The press pulse is at cycle t, the long pulse at t + LONG_PRESS_CYCLES.
- o_toggle: inverts on the edge that registers o_press; otherwise holds.
- Key held through reset release: the synchroniser reaches the pressed value after 2 edges, then a normal debounce follows, giving one o_press at edge 2 + DEBOUNCE_CYCLES.
- Reset asserted mid-debounce or mid-hold: everything returns immediately to reset values, and no pulse is emitted.
- Simultaneous events on different keys are each reported in their own bit on the same cycle.

Test Plan:
- DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1: after reset with i_key=5'b11111 held for 50 cycles -> all outputs stay 0.
- Drive i_key[0] 1->0 cleanly -> o_level[0] rises on edge 6 counted from the first sampling edge; o_press[0] is high that single cycle; o_toggle[0]=1.
- Bounce: i_key[1] low for 3 cycles, high 1, low 2, high -> no o_press[1], o_level[1] stays 0. Then low for 10 cycles -> exactly one o_press[1].
- Hold i_key[2] low for 40 cycles after o_press[2] -> o_long[2] pulses once, 20 cycles after o_press[2]. Release -> one o_release[2], o_level[2]=0. A second press-and-hold repeats o_long once.
- Press i_key[3] and release 10 cycles after o_press[3] -> o_release[3] occurs and o_long[3] never asserts. Two full press/release cycles -> o_toggle[3] goes 1 then 0.
- Press i_key[0] and i_key[4] on the same edge -> o_press=5'b10001 on one cycle.
- Assert i_rst_n low mid-hold, 10 cycles after the press with key still low -> outputs clear immediately. After release of reset with the key still low -> o_press[4] after 2+4 edges.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: per-key conditioning for push-buttons and mode switches.
// Each channel synchronises its raw pin and debounces it. It then produces a
// clean level, press/release pulses, a one-shot long-press pulse and a toggle.
//
// Ports:
//   i_clk      system clock (rising edge)
//   i_rst_n    asynchronous active-low reset
//   i_key      raw asynchronous key pins            [N_KEYS]
//   o_level    debounced pressed level (1=pressed)  [N_KEYS]
//   o_press    one-cycle pulse on accepted press    [N_KEYS]
//   o_release  one-cycle pulse on accepted release  [N_KEYS]
//   o_long     one-cycle pulse after a long hold    [N_KEYS]
//   o_toggle   flips on every press                 [N_KEYS]

// One key channel: sync, debounce, pulse generation, long-press FSM, toggle.
module key_chan #(
  parameter int DEBOUNCE_CYCLES   = 65536,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_toggle
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  // Pin value when the key is not pressed; also the synchroniser reset value.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_DONE} state_e;

  logic              sync1_q, sync2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  state_e            state_q, state_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  logic long_q, long_d, toggle_q, toggle_d;
  logic s, accept;

  always_comb begin
    s      = sync2_q ^ IDLE_PIN;  // 1 = pressed
    // Accept the new level once it has differed for DEBOUNCE_CYCLES cycles.
    accept = (s != level_q) && (db_cnt_q == DB_LAST);

    db_cnt_d  = ((s == level_q) || accept) ? '0 : db_cnt_q + 1'b1;
    level_d   = accept ? s : level_q;
    press_d   = accept & s;
    release_d = accept & ~s;
    toggle_d  = toggle_q ^ press_d;

    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (press_d) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // A release on the same edge wins over the long-press pulse.
        if (release_d) begin
          state_d = RELEASED;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_DONE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG_DONE: begin
        // Hold counter stays saturated until release.
        if (release_d) begin
          state_d = RELEASED;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = RELEASED;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      state_q   <= RELEASED;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      toggle_q  <= toggle_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_toggle  = toggle_q;
endmodule

module key_conditioner #(
  parameter int N_KEYS            = 5,
  parameter int DEBOUNCE_CYCLES   = 65536,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_toggle
);
  // Channels are independent; each instance takes one bit of every vector.
  key_chan #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
    .ACTIVE_LOW       (ACTIVE_LOW)
  ) u_chan [N_KEYS-1:0] (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_key    (i_key),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_toggle (o_toggle)
  );
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with small debounce/long-press constants.
// A window-based model predicts every output each cycle; directed literal
// checks pin the timing of the model itself.
module tb_key_conditioner;
  localparam int NK = 5;
  localparam int DB = 4;
  localparam int LP = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] o_level, o_press, o_release, o_long, o_toggle;

  int n_tests = 0;
  int n_fail  = 0;
  int press_cnt [NK];
  int rel_cnt   [NK];
  int long_cnt  [NK];

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_toggle(o_toggle)
  );

  always #5 clk = ~clk;

  // Model: the pressed level changes when the last DB pin samples, seen two
  // edges late through the synchroniser, all disagree with the current level.
  logic [DB+1:0] hist [NK];
  logic [NK-1:0] m_level = '0, m_press = '0, m_release = '0;
  logic [NK-1:0] m_long = '0, m_toggle = '0, m_fired = '0;
  int            m_cyc = 0;
  int            m_press_cyc [NK];

  initial for (int k = 0; k < NK; k++) begin
    hist[k] = '0; m_press_cyc[k] = 0;
    press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0;
      m_level <= '0; m_press <= '0; m_release <= '0;
      m_long <= '0; m_toggle <= '0; m_fired <= '0;
      for (int k = 0; k < NK; k++) begin
        hist[k] <= '0;
        m_press_cyc[k] <= 0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      for (int k = 0; k < NK; k++) begin
        automatic bit diff = 1'b1;
        hist[k] <= {hist[k][DB:0], ~key[k]};
        for (int j = 1; j <= DB; j++)
          if (hist[k][j] == m_level[k]) diff = 1'b0;
        m_press[k] <= 1'b0; m_release[k] <= 1'b0; m_long[k] <= 1'b0;
        if (diff) begin
          m_level[k] <= ~m_level[k];
          if (!m_level[k]) begin
            m_press[k]     <= 1'b1;
            m_toggle[k]    <= ~m_toggle[k];
            m_press_cyc[k] <= m_cyc + 1;
            m_fired[k]     <= 1'b0;
          end else begin
            m_release[k] <= 1'b1;
          end
        end else if (m_level[k] && !m_fired[k] &&
                     (m_cyc + 1 - m_press_cyc[k]) == LP) begin
          m_long[k]  <= 1'b1;
          m_fired[k] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [NK-1:0] act,
                     input logic [NK-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model on the falling edge, and tally DUT events.
  task automatic cmp_model();
    n_tests++;
    if ({o_level, o_press, o_release, o_long, o_toggle} !==
        {m_level, m_press, m_release, m_long, m_toggle}) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t lvl %b/%b prs %b/%b rel %b/%b lng %b/%b tog %b/%b",
               $time, o_level, m_level, o_press, m_press, o_release, m_release,
               o_long, m_long, o_toggle, m_toggle);
    end
    for (int k = 0; k < NK; k++) begin
      if (o_press[k])   press_cnt[k]++;
      if (o_release[k]) rel_cnt[k]++;
      if (o_long[k])    long_cnt[k]++;
    end
  endtask

  // Advance n rising edges; inputs change 2 time units after a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
    #2;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(50);
    chk("idle_level", o_level, '0);
    chk("idle_toggle", o_toggle, '0);
    chk("idle_press_cnt", 5'(press_cnt[0] + press_cnt[1] + press_cnt[2] +
                             press_cnt[3] + press_cnt[4]), '0);

    // Clean press on key 0: level rises on edge 2+DB.
    key[0] = 1'b0;
    step(5);
    chk("k0_level_before", o_level, 5'b00000);
    step(1);
    chk("k0_level_edge6", o_level, 5'b00001);
    chk("k0_press_edge6", o_press, 5'b00001);
    chk("k0_toggle", o_toggle, 5'b00001);
    step(1);
    chk("k0_press_one_cycle", o_press, 5'b00000);
    key[0] = 1'b1;
    step(5);
    chk("k0_release_before", o_release, 5'b00000);
    step(1);
    chk("k0_release_edge6", o_release, 5'b00001);
    chk("k0_level_low", o_level, 5'b00000);
    step(4);

    // Bounce on key 1: runs of 3 and 2 never reach DB.
    key[1] = 1'b0; step(3);
    key[1] = 1'b1; step(1);
    key[1] = 1'b0; step(2);
    key[1] = 1'b1; step(10);
    chk("k1_bounce_level", o_level, 5'b00000);
    chk("k1_bounce_press", 5'(press_cnt[1]), 5'd0);
    key[1] = 1'b0; step(10);
    chk("k1_one_press", 5'(press_cnt[1]), 5'd1);
    chk("k1_level", o_level, 5'b00010);
    key[1] = 1'b1; step(10);

    // Long press on key 2: o_long LP cycles after o_press.
    key[2] = 1'b0;
    step(6);
    chk("k2_press", o_press, 5'b00100);
    step(LP - 1);
    chk("k2_long_early", o_long, 5'b00000);
    step(1);
    chk("k2_long", o_long, 5'b00100);
    step(1);
    chk("k2_long_one_cycle", o_long, 5'b00000);
    step(25);
    chk("k2_long_once", 5'(long_cnt[2]), 5'd1);
    key[2] = 1'b1; step(10);
    chk("k2_release_cnt", 5'(rel_cnt[2]), 5'd1);
    chk("k2_level_low", o_level, 5'b00000);
    key[2] = 1'b0; step(40);
    chk("k2_second_long", 5'(long_cnt[2]), 5'd2);
    key[2] = 1'b1; step(10);

    // Short presses on key 3: no long, toggle 1 then 0.
    key[3] = 1'b0; step(6);
    chk("k3_toggle_1", o_toggle & 5'b01000, 5'b01000);
    step(10);
    key[3] = 1'b1; step(10);
    chk("k3_release", 5'(rel_cnt[3]), 5'd1);
    key[3] = 1'b0; step(6);
    chk("k3_toggle_0", o_toggle & 5'b01000, 5'b00000);
    step(10);
    key[3] = 1'b1; step(10);
    chk("k3_no_long", 5'(long_cnt[3]), 5'd0);

    // Simultaneous presses on keys 0 and 4.
    key[0] = 1'b0; key[4] = 1'b0;
    step(6);
    chk("k04_press", o_press, 5'b10001);
    key[0] = 1'b1; key[4] = 1'b1;
    step(10);

    // Reset mid-hold on key 4, key still held across reset release.
    key[4] = 1'b0;
    step(6);
    chk("k4_press", o_press, 5'b10000);
    step(10);
    rst_n = 1'b0;
    #1;
    chk("rst_level", o_level, '0);
    chk("rst_toggle", o_toggle, '0);
    chk("rst_long", o_long, '0);
    step(3);
    rst_n = 1'b1;
    step(5);
    chk("k4_post_rst_before", o_press, 5'b00000);
    step(1);
    chk("k4_post_rst_press", o_press, 5'b10000);
    key[4] = 1'b1;
    step(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
